// File: rtl/ps2_rx_fifo_if.sv
// Read-side bus of the PS/2 receiver: head byte, valid/ready handshake and occupancy.
interface ps2_rx_fifo_if #(
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [CW-1:0] fifo_count;

  modport master (output rd_data, output rd_valid, output fifo_count, input rd_ready);
  modport slave  (input rd_data, input rd_valid, input fifo_count, output rd_ready);
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: sync + glitch filter, frame decoder with
// parity/stop/timeout checks, and a scancode FIFO with a ready/valid read port.
module ps2_rx_fifo #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter bit          CHECK_PARITY   = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  ps2_rx_fifo_if.master rd,
  output logic          parity_err,
  output logic          frame_err,
  output logic          timeout_err,
  output logic          overflow
);
  localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // index 0 carries the PS/2 clock line, index 1 the data line
  logic [1:0]     sync1, sync2, filt;
  logic [FCW-1:0] fcnt [2];
  logic           clk_d;

  state_t         state;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;
  logic           par_bit;
  logic [TCW-1:0] to_cnt;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count, count_nxt;
  logic           valid_q;

  logic sample, bit_in, tmo, stop_ev, bad_stop, bad_par, push, pop, full, do_push;

  // Synchroniser and persistence filter for both pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      filt    <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
      clk_d   <= 1'b1;
    end else begin
      sync1 <= {ps2_data, ps2_clk};
      sync2 <= sync1;
      clk_d <= filt[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FCW'(FILTER_LEN - 1)) begin
          filt[i] <= ~filt[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FCW'(1);
        end
      end
    end
  end

  // Frame evaluation and FIFO control decided in the same cycle as the stop sample
  always_comb begin
    sample    = clk_d & ~filt[0];
    bit_in    = filt[1];
    tmo       = (state != IDLE) && !sample && (to_cnt == TCW'(TIMEOUT_CYCLES - 1));
    stop_ev   = (state == STOP) && sample;
    bad_stop  = stop_ev && !bit_in;
    bad_par   = stop_ev && bit_in && CHECK_PARITY && !(^{shreg, par_bit});
    push      = stop_ev && bit_in && !bad_par;
    full      = (count == CW'(FIFO_DEPTH));
    pop       = valid_q && rd.rd_ready;
    do_push   = push && (!full || pop);
    count_nxt = count + CW'(do_push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      to_cnt      <= '0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      parity_err  <= bad_par;
      frame_err   <= bad_stop;
      timeout_err <= tmo;
      to_cnt      <= (state == IDLE || sample || tmo) ? '0 : to_cnt + TCW'(1);
      if (tmo) begin
        state <= IDLE;
      end else if (sample) begin
        case (state)
          IDLE: if (!bit_in) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
          DATA: begin
            shreg   <= {bit_in, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= bit_in;
            state   <= STOP;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      valid_q  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count    <= count_nxt;
      valid_q  <= (count_nxt != '0);
      overflow <= push && full && !pop;
    end
  end

  // Storage needs no reset: the head is only visible while valid_q is set
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  assign rd.rd_data    = valid_q ? mem[rd_ptr] : 8'h00;
  assign rd.rd_valid   = valid_q;
  assign rd.fifo_count = count;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: directed scenarios plus randomized frames
// against a queue-based model of the frame rules and FIFO.
module tb_ps2_rx_fifo;
  localparam int F = 4, DEPTH = 8, TC = 400, HP = 12;

  logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic perr1, ferr1, to1, ovf1, perr2, ferr2, to2, ovf2;
  int   checks = 0, failures = 0;

  ps2_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) rd1 ();
  ps2_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) rd2 ();

  ps2_rx_fifo #(.FILTER_LEN(F), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TC), .CHECK_PARITY(1'b1)) dut (
    .clk(clk), .reset(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd(rd1),
    .parity_err(perr1), .frame_err(ferr1), .timeout_err(to1), .overflow(ovf1));

  ps2_rx_fifo #(.FILTER_LEN(F), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TC), .CHECK_PARITY(1'b0)) dut_np (
    .clk(clk), .reset(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd(rd2),
    .parity_err(perr2), .frame_err(ferr2), .timeout_err(to2), .overflow(ovf2));

  always #5 clk = ~clk;

  // Reference model: frame outcome from the protocol rules, FIFO as a queue
  logic [7:0] q [$];
  int         cyc = 0, pend_cyc = -1, fall_cyc = 0;
  logic [7:0] pend_data;
  logic       pend_par, pend_stop;
  logic       m_perr = 1'b0, m_ferr = 1'b0, m_ovf = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
    m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    if (rst) begin
      q.delete();
      pend_cyc = -1;
    end else begin
      if (q.size() != 0 && rd1.rd_ready) void'(q.pop_front());
      if (cyc == pend_cyc) begin
        pend_cyc = -1;
        if (!pend_stop) m_ferr = 1'b1;
        else if ($countones({pend_data, pend_par}) % 2 == 0) m_perr = 1'b1;
        else if (q.size() >= DEPTH) m_ovf = 1'b1;
        else q.push_back(pend_data);
      end
    end
  end

  initial forever begin
    @(posedge rst);
    q.delete();
    pend_cyc = -1;
  end

  // Sticky observations of the main DUT's pulses and rd_valid rises
  int cnt_perr = 0, cnt_ferr = 0, cnt_to = 0, cnt_ovf = 0, cnt_rise = 0;
  int valid_rise_cyc = -1, to_cyc = -1;
  logic prev_v = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    cnt_perr += int'(perr1);
    cnt_ferr += int'(ferr1);
    cnt_to   += int'(to1);
    cnt_ovf  += int'(ovf1);
    if (to1 === 1'b1) to_cyc = cyc;
    if (rd1.rd_valid === 1'b1 && !prev_v) begin
      valid_rise_cyc = cyc;
      cnt_rise++;
    end
    prev_v = (rd1.rd_valid === 1'b1);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog sim_time got=expired want=finish");
    $fatal(1);
  end

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  task automatic clear_obs();
    cnt_perr = 0; cnt_ferr = 0; cnt_to = 0; cnt_ovf = 0; cnt_rise = 0;
  endtask

  // One PS/2 bit: data set, clk high for HP cycles, then low for HP cycles
  task automatic ps2_bit(input logic b, input logic glitch, input logic arm, input logic pop_push);
    ps2_data = b;
    for (int i = 1; i <= HP; i++) begin
      @(negedge clk);
      if (glitch && i == 4) ps2_clk = 1'b0;
      if (glitch && i == 5) ps2_clk = 1'b1;
    end
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    if (arm) pend_cyc = cyc + 3 + F;
    for (int i = 1; i <= HP; i++) begin
      @(negedge clk);
      if (pop_push && i == F + 2) rd1.rd_ready = 1'b1;
      if (pop_push && i == F + 3) rd1.rd_ready = 1'b0;
      if (glitch && i == 8)      ps2_data = ~b;
      if (glitch && i == 7 + F)  ps2_data = b;
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input logic glitch, input logic pop_push);
    pend_data = d; pend_par = par; pend_stop = stop;
    ps2_bit(1'b0, glitch, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], glitch, 1'b0, 1'b0);
    ps2_bit(par, glitch, 1'b0, 1'b0);
    ps2_bit(stop, glitch, 1'b1, pop_push);
    ps2_data = 1'b1;
    repeat (HP) @(negedge clk);
  endtask

  task automatic pop_one();
    rd1.rd_ready = 1'b1;
    @(negedge clk);
    rd1.rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rd1.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", rd1.rd_valid); end
    checks++; if (rd1.rd_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h want=00", rd1.rd_data); end
    checks++; if (rd1.fifo_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", rd1.fifo_count); end
    checks++; if ({perr1, ferr1, to1, ovf1} !== 4'b0) begin failures++; $display("FAIL reset_pulses got=%b want=0000", {perr1, ferr1, to1, ovf1}); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (rd1.rd_valid !== 1'b0 || rd1.fifo_count !== 4'd0) begin failures++; $display("FAIL post_reset_idle got=%b/%0d want=0/0", rd1.rd_valid, rd1.fifo_count); end
  endtask

  task automatic test_clean();
    clear_obs();
    rd1.rd_ready = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (valid_rise_cyc != fall_cyc + 3 + F) begin failures++; $display("FAIL clean_latency got=%0d want=%0d", valid_rise_cyc, fall_cyc + 3 + F); end
    checks++; if (rd1.rd_data !== 8'h1C || rd1.rd_valid !== 1'b1) begin failures++; $display("FAIL clean_data got=%h/%b want=1c/1", rd1.rd_data, rd1.rd_valid); end
    checks++; if (rd1.fifo_count !== 4'd1) begin failures++; $display("FAIL clean_count got=%0d want=1", rd1.fifo_count); end
    checks++; if (cnt_perr + cnt_ferr + cnt_to + cnt_ovf != 0) begin failures++; $display("FAIL clean_errors got=%0d want=0", cnt_perr + cnt_ferr + cnt_to + cnt_ovf); end
    pop_one();
    checks++; if (rd1.fifo_count !== 4'd0 || rd1.rd_data !== 8'h00) begin failures++; $display("FAIL clean_pop got=%0d/%h want=0/00", rd1.fifo_count, rd1.rd_data); end
  endtask

  task automatic test_parity();
    clear_obs();
    rd2.rd_ready = 1'b0;
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (cnt_perr != 1 || cnt_ferr != 0) begin failures++; $display("FAIL parity_pulse got=%0d/%0d want=1/0", cnt_perr, cnt_ferr); end
    checks++; if (rd1.fifo_count !== 4'd0) begin failures++; $display("FAIL parity_count got=%0d want=0", rd1.fifo_count); end
    checks++; if (rd2.rd_valid !== 1'b1 || rd2.rd_data !== 8'h1C) begin failures++; $display("FAIL noparity_push got=%b/%h want=1/1c", rd2.rd_valid, rd2.rd_data); end
    rd2.rd_ready = 1'b1;
    clear_obs();
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (cnt_ferr != 1 || cnt_perr != 0) begin failures++; $display("FAIL stop_err got=%0d/%0d want=1/0", cnt_ferr, cnt_perr); end
    checks++; if (rd1.fifo_count !== 4'd0) begin failures++; $display("FAIL stop_count got=%0d want=0", rd1.fifo_count); end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    logic [7:0] exp_q [$];
    clear_obs();
    rd1.rd_ready = 1'b0;
    for (int b = 1; b <= 9; b++) begin
      d = 8'(b);
      send_frame(d, odd_par(d), 1'b1, 1'b0, 1'b0);
      if (b == 8) begin
        checks++; if (cnt_ovf != 0 || rd1.fifo_count !== 4'd8) begin failures++; $display("FAIL fill_8 got=%0d/%0d want=0/8", cnt_ovf, rd1.fifo_count); end
      end
    end
    checks++; if (cnt_ovf != 1 || rd1.fifo_count !== 4'd8) begin failures++; $display("FAIL overflow_9 got=%0d/%0d want=1/8", cnt_ovf, rd1.fifo_count); end
    clear_obs();
    send_frame(8'h0A, odd_par(8'h0A), 1'b1, 1'b0, 1'b1);
    checks++; if (cnt_ovf != 0 || rd1.fifo_count !== 4'd8) begin failures++; $display("FAIL full_push_pop got=%0d/%0d want=0/8", cnt_ovf, rd1.fifo_count); end
    checks++; if (rd1.rd_data !== 8'h02) begin failures++; $display("FAIL full_head got=%h want=02", rd1.rd_data); end
    exp_q = q;
    rd1.rd_ready = 1'b1;
    foreach (exp_q[i]) begin
      checks++; if (rd1.rd_data !== exp_q[i]) begin failures++; $display("FAIL drain_%0d got=%h want=%h", i, rd1.rd_data, exp_q[i]); end
      @(negedge clk);
    end
    rd1.rd_ready = 1'b0;
    checks++; if (rd1.fifo_count !== 4'd0 || rd1.rd_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%0d/%b want=0/0", rd1.fifo_count, rd1.rd_valid); end
  endtask

  task automatic test_timeout();
    int ev;
    clear_obs();
    ps2_bit(1'b0, 1'b0, 1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0, 1'b0, 1'b0);
    ps2_bit(1'b0, 1'b0, 1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0, 1'b0, 1'b0);
    ev = fall_cyc + 3 + F;
    repeat (TC + 40) @(negedge clk);
    checks++; if (cnt_to != 1) begin failures++; $display("FAIL timeout_count got=%0d want=1", cnt_to); end
    checks++; if (to_cyc < ev + TC - 2 || to_cyc > ev + TC + 2) begin failures++; $display("FAIL timeout_time got=%0d want=%0d", to_cyc, ev + TC); end
    checks++; if (rd1.fifo_count !== 4'd0) begin failures++; $display("FAIL timeout_nopush got=%0d want=0", rd1.fifo_count); end
    clear_obs();
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (rd1.rd_data !== 8'hF0) begin failures++; $display("FAIL after_timeout got=%h want=f0", rd1.rd_data); end
    checks++; if (cnt_perr + cnt_ferr + cnt_to != 0) begin failures++; $display("FAIL after_timeout_err got=%0d want=0", cnt_perr + cnt_ferr + cnt_to); end
    pop_one();
  endtask

  task automatic test_glitch();
    clear_obs();
    send_frame(8'hAA, odd_par(8'hAA), 1'b1, 1'b1, 1'b0);
    checks++; if (rd1.rd_data !== 8'hAA || rd1.fifo_count !== 4'd1) begin failures++; $display("FAIL glitch_data got=%h/%0d want=aa/1", rd1.rd_data, rd1.fifo_count); end
    checks++; if (cnt_perr + cnt_ferr + cnt_to + cnt_ovf != 0) begin failures++; $display("FAIL glitch_errors got=%0d want=0", cnt_perr + cnt_ferr + cnt_to + cnt_ovf); end
    pop_one();
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'h33;
    send_frame(8'h11, odd_par(8'h11), 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, odd_par(8'h22), 1'b1, 1'b0, 1'b0);
    checks++; if (rd1.fifo_count !== 4'd2) begin failures++; $display("FAIL pre_reset_count got=%0d want=2", rd1.fifo_count); end
    ps2_bit(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(d[i], 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (rd1.rd_valid !== 1'b0 || rd1.rd_data !== 8'h00 || rd1.fifo_count !== 4'd0) begin failures++; $display("FAIL midreset_outputs got=%b/%h/%0d want=0/00/0", rd1.rd_valid, rd1.rd_data, rd1.fifo_count); end
    checks++; if ({perr1, ferr1, to1, ovf1} !== 4'b0) begin failures++; $display("FAIL midreset_pulses got=%b want=0000", {perr1, ferr1, to1, ovf1}); end
    @(negedge clk);
    rst = 1'b0;
    clear_obs();
    for (int i = 5; i < 8; i++) ps2_bit(d[i], 1'b0, 1'b0, 1'b0);
    ps2_bit(odd_par(d), 1'b0, 1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (TC + 40) @(negedge clk);
    checks++; if (cnt_rise != 0 || rd1.fifo_count !== 4'd0) begin failures++; $display("FAIL tail_push got=%0d/%0d want=0/0", cnt_rise, rd1.fifo_count); end
    checks++; if (cnt_perr + cnt_ovf != 0) begin failures++; $display("FAIL tail_errors got=%0d want=0", cnt_perr + cnt_ovf); end
    send_frame(8'h5A, odd_par(8'h5A), 1'b1, 1'b0, 1'b0);
    checks++; if (rd1.rd_data !== 8'h5A || rd1.fifo_count !== 4'd1) begin failures++; $display("FAIL after_midreset got=%h/%0d want=5a/1", rd1.rd_data, rd1.fifo_count); end
    pop_one();
  endtask

  task automatic test_random();
    logic       done;
    logic [7:0] d, ed;
    logic [3:0] ec;
    logic       par, stop;
    int         r;
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 14; n++) begin
          d    = 8'($urandom);
          r    = int'($urandom_range(0, 7));
          par  = odd_par(d) ^ (r == 0);
          stop = (r != 1);
          send_frame(d, par, stop, 1'b0, 1'b0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          rd1.rd_ready = ($urandom_range(0, 199) == 0);
        end
      end
      begin
        while (!done) begin
          @(negedge clk);
          ec = 4'(q.size());
          ed = (q.size() != 0) ? q[0] : 8'h00;
          checks++;
          if (rd1.rd_valid !== (q.size() != 0) || rd1.fifo_count !== ec || rd1.rd_data !== ed) begin
            failures++;
            $display("FAIL rand_fifo cyc=%0d got=%b/%0d/%h want=%b/%0d/%h", cyc, rd1.rd_valid, rd1.fifo_count, rd1.rd_data, q.size() != 0, ec, ed);
          end
          checks++;
          if ({perr1, ferr1, ovf1, to1} !== {m_perr, m_ferr, m_ovf, 1'b0}) begin
            failures++;
            $display("FAIL rand_pulses cyc=%0d got=%b want=%b", cyc, {perr1, ferr1, ovf1, to1}, {m_perr, m_ferr, m_ovf, 1'b0});
          end
        end
      end
    join
    rd1.rd_ready = 1'b1;
    repeat (DEPTH + 2) @(negedge clk);
    rd1.rd_ready = 1'b0;
    ec = 4'(q.size());
    checks++; if (rd1.fifo_count !== ec || rd1.rd_valid !== 1'b0) begin failures++; $display("FAIL rand_drain got=%0d/%b want=%0d/0", rd1.fifo_count, rd1.rd_valid, ec); end
  endtask

  initial begin
    rd1.rd_ready = 1'b0;
    rd2.rd_ready = 1'b1;
    test_reset();
    test_clean();
    test_parity();
    test_overflow();
    test_timeout();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
